// File: rtl/stego_lsb_embedder_pkg.sv
// Shared constants, state encoding and block geometry for the LSB stego stages.
// Optional blk_count output is enabled with STEGO_BLK_CNT_EN.
package stego_pkg;
    localparam int PIX_W_DEF    = 8;
    localparam int BLK_W_DEF    = 64;
    localparam int LSB_BITS_DEF = 1;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t EMBED = 1'b1;

    function automatic int npix(input int blk_w, input int lsb_bits);
        return blk_w / lsb_bits;
    endfunction
endpackage

// File: rtl/stego_lsb_embedder_if.sv
// Ciphertext-in, cover-pixel-in and stego-pixel-out handshakes of the embedder.
// Optional blk_count output is enabled with STEGO_BLK_CNT_EN.
interface stego_lsb_embedder_if
    import stego_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int BLK_W = BLK_W_DEF
);
    logic [1:BLK_W]   ct_data;
    logic             ct_valid;
    logic             ct_ready;
    logic [PIX_W-1:0] pix_in;
    logic             pix_in_valid;
    logic             pix_in_ready;
    logic [PIX_W-1:0] pix_out;
    logic             pix_out_valid;
    logic             pix_out_ready;
    logic             blk_done;
    logic             busy;

    modport master (
        output ct_data, ct_valid, pix_in, pix_in_valid, pix_out_ready,
        input  ct_ready, pix_in_ready, pix_out, pix_out_valid,
        input  blk_done, busy
    );

    modport slave (
        input  ct_data, ct_valid, pix_in, pix_in_valid, pix_out_ready,
        output ct_ready, pix_in_ready, pix_out, pix_out_valid,
        output blk_done, busy
    );
endinterface

// File: rtl/stego_lsb_embedder_bit_shifter.sv
// Ciphertext shift register: load a block, then hand out LSB_BITS per shift.
// Shared with the extractor stage; bit 1 (DES numbering) leaves first.
module stego_bit_shifter
    import stego_pkg::*;
#(
    parameter int BLK_W    = BLK_W_DEF,
    parameter int LSB_BITS = LSB_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                shift,
    input  logic [1:BLK_W]      din,
    output logic [LSB_BITS-1:0] bits
);
    logic [1:BLK_W] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[LSB_BITS+1:BLK_W], {LSB_BITS{1'b0}}};
        end
    end

    // earlier ciphertext bit lands in the higher cover LSB
    assign bits = sr[1:LSB_BITS];
endmodule

// File: rtl/stego_lsb_embedder.sv
// Hides one ciphertext block in the LSBs of NPIX cover pixels.
// Define STEGO_BLK_CNT_EN to add the 16-bit blk_count output.
module stego_lsb_embedder
    import stego_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int BLK_W    = BLK_W_DEF,
    parameter int LSB_BITS = LSB_BITS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    stego_lsb_embedder_if.slave bus
`ifdef STEGO_BLK_CNT_EN
    ,
    output logic [15:0] blk_count
`endif
);
    localparam int NPIX  = npix(BLK_W, LSB_BITS);
    localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [LSB_BITS-1:0] bits;
    logic               load;
    logic               accept;
    logic               last;

    assign bus.ct_ready     = (state == IDLE);
    assign bus.busy         = (state == EMBED);
    assign bus.pix_in_ready = (state == EMBED) &&
                              (!bus.pix_out_valid || bus.pix_out_ready);

    assign load   = (state == IDLE) && bus.ct_valid;
    assign accept = bus.pix_in_valid && bus.pix_in_ready;
    assign last   = (cnt == CNT_W'(NPIX - 1));

    stego_bit_shifter #(
        .BLK_W    (BLK_W),
        .LSB_BITS (LSB_BITS)
    ) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (accept),
        .din   (bus.ct_data),
        .bits  (bits)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.pix_out       <= '0;
            bus.pix_out_valid <= 1'b0;
            bus.blk_done      <= 1'b0;
        end else begin
            bus.blk_done <= accept && last;
            if (accept) begin
                bus.pix_out       <= {bus.pix_in[PIX_W-1:LSB_BITS], bits};
                bus.pix_out_valid <= 1'b1;
            end else if (bus.pix_out_ready) begin
                bus.pix_out_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (bus.ct_valid) begin
                        state <= EMBED;
                        cnt   <= '0;
                    end
                end
                EMBED: begin
                    if (accept) begin
                        cnt <= last ? '0 : cnt + 1'b1;
                        if (last) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STEGO_BLK_CNT_EN
    logic [15:0] blk_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (bus.blk_done) begin
            blk_cnt <= blk_cnt + 16'd1;
        end
    end

    assign blk_count = blk_cnt;
`endif
endmodule

// File: tb/tb_stego_lsb_embedder.sv
// Scoreboard bench for stego_lsb_embedder (LSB_BITS=1 and LSB_BITS=2 instances).
// Define STEGO_BLK_CNT_EN to also exercise blk_count.
module tb_stego_lsb_embedder;
    import stego_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stego_lsb_embedder_if #(.PIX_W(8), .BLK_W(64)) b1 ();
    stego_lsb_embedder_if #(.PIX_W(8), .BLK_W(64)) b2 ();

`ifdef STEGO_BLK_CNT_EN
    logic [15:0] cnt1, cnt2;
`endif

    stego_lsb_embedder #(.PIX_W(8), .BLK_W(64), .LSB_BITS(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
`ifdef STEGO_BLK_CNT_EN
        , .blk_count (cnt1)
`endif
    );

    stego_lsb_embedder #(.PIX_W(8), .BLK_W(64), .LSB_BITS(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
`ifdef STEGO_BLK_CNT_EN
        , .blk_count (cnt2)
`endif
    );

    // shared stimulus, steered to one instance by sel
    logic        sel = 1'b0;
    logic [63:0] ct = '0;
    logic        ct_valid = 1'b0;
    logic [7:0]  pix_in = '0;
    logic        pix_in_valid = 1'b0;
    logic        pix_out_ready = 1'b1;

    assign b1.ct_data       = ct;
    assign b2.ct_data       = ct;
    assign b1.ct_valid      = ct_valid && !sel;
    assign b2.ct_valid      = ct_valid && sel;
    assign b1.pix_in        = pix_in;
    assign b2.pix_in        = pix_in;
    assign b1.pix_in_valid  = pix_in_valid && !sel;
    assign b2.pix_in_valid  = pix_in_valid && sel;
    assign b1.pix_out_ready = pix_out_ready;
    assign b2.pix_out_ready = pix_out_ready;

    logic       o_ct_ready, o_pin_ready, o_pout_valid, o_done, o_busy;
    logic [7:0] o_pout;
    assign o_ct_ready   = sel ? b2.ct_ready      : b1.ct_ready;
    assign o_pin_ready  = sel ? b2.pix_in_ready  : b1.pix_in_ready;
    assign o_pout_valid = sel ? b2.pix_out_valid : b1.pix_out_valid;
    assign o_pout       = sel ? b2.pix_out       : b1.pix_out;
    assign o_done       = sel ? b2.blk_done      : b1.blk_done;
    assign o_busy       = sel ? b2.busy          : b1.busy;

    int compared = 0;
    int mismatched = 0;
    int outs = 0;
    int dones = 0;
    logic [7:0] exp_q[$];
    logic [7:0] hand_q[$];

    function automatic void check(input string name,
                                  input logic [63:0] act,
                                  input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic logic [7:0] exp_pix(input logic [63:0] c, input int i,
                                           input logic [7:0] p, input int l);
        logic [63:0] s;
        s = c << (i * l);
        if (l == 2) return {p[7:2], s[63:62]};
        return {p[7:1], s[63]};
    endfunction

    // monitor: pops on every output transfer, tracks blk_done timing
    int   acc = 0;
    logic done_exp = 1'b0;
    always @(negedge clk) begin
        int np;
        np = sel ? 32 : 64;
        if (rst_n) begin
            if (o_pout_valid && pix_out_ready) begin
                outs++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL extra_out: got %0h, expected none", o_pout);
                end else begin
                    check("pix_out", 64'(o_pout), 64'(exp_q.pop_front()));
                end
            end
            if (o_done) dones++;
            if (o_done || done_exp)
                check("blk_done", 64'(o_done), 64'(done_exp));
            done_exp = pix_in_valid && o_pin_ready && (acc == np - 1);
            if (pix_in_valid && o_pin_ready)
                acc = (acc == np - 1) ? 0 : acc + 1;
        end else begin
            done_exp = 1'b0;
            acc = 0;
        end
    end

    // tasks start and end just after a rising edge
    task automatic load(input logic [63:0] c, output int waited);
        int n;
        ct = c;
        ct_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!o_ct_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ct_accept", 64'(o_ct_ready), 64'd1);
        waited = n;
        @(posedge clk);
        #1 ct_valid = 1'b0;
    endtask

    task automatic feed(input logic [63:0] c, input int mode,
                        input int stall_at, input int count);
        int l, np, n;
        logic [7:0] p, hold;
        l = sel ? 2 : 1;
        np = (count > 0) ? count : 64 / l;
        for (int i = 0; i < np; i++) begin
            case (mode)
                0: p = 8'hFF;
                1: p = 8'(i);
                default: p = 8'h00;
            endcase
            pix_in = p;
            pix_in_valid = 1'b1;
            if (i == stall_at) begin
                pix_out_ready = 1'b0;
                hold = '0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k == 0) hold = o_pout;
                    check("stall_in_ready", 64'(o_pin_ready), 64'd0);
                    check("stall_valid", 64'(o_pout_valid), 64'd1);
                    check("stall_hold", 64'(o_pout), 64'(hold));
                    @(posedge clk);
                    #1;
                end
                pix_out_ready = 1'b1;
            end
            n = 0;
            @(negedge clk);
            while (!o_pin_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!o_pin_ready) begin
                check("pix_accept_timeout", 64'(o_pin_ready), 64'd1);
                break;
            end
            if (hand_q.size() > 0) exp_q.push_back(hand_q.pop_front());
            else exp_q.push_back(exp_pix(c, i, p, l));
            @(posedge clk);
            #1;
        end
        pix_in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w;
        logic [63:0] c1;
        c1 = 64'hC1F765C38141799E;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ct_ready", 64'(o_ct_ready), 64'd1);
        check("rst_pin_ready", 64'(o_pin_ready), 64'd0);
        check("rst_pout", 64'(o_pout), 64'd0);
        check("rst_pout_valid", 64'(o_pout_valid), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // block 1 then block 2 back-to-back
        hand_q = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF};
        load(c1, w);
        check("busy_embed", 64'(o_busy), 64'd1);
        feed(c1, 0, -1, 0);
        for (int i = 0; i < 64; i++) hand_q.push_back(8'(i) | 8'h01);
        load(64'hFFFF_FFFF_FFFF_FFFF, w);
        check("b2b_wait", 64'(w), 64'd0);
        feed(64'hFFFF_FFFF_FFFF_FFFF, 1, -1, 0);
        @(negedge clk);
        check("end_ct_ready", 64'(o_ct_ready), 64'd1);
        check("end_busy", 64'(o_busy), 64'd0);
        drain();
        check("outs_2blk", 64'(outs), 64'd128);
        check("dones_2blk", 64'(dones), 64'd2);

        // backpressure mid-block
        outs = 0;
        dones = 0;
        load(64'h0123_4567_89AB_CDEF, w);
        feed(64'h0123_4567_89AB_CDEF, 1, 30, 0);
        drain();
        check("outs_stall", 64'(outs), 64'd64);
        check("dones_stall", 64'(dones), 64'd1);

        // two LSBs per pixel
        sel = 1'b1;
        outs = 0;
        dones = 0;
        @(posedge clk);
        #1;
        hand_q = '{8'h03, 8'h00, 8'h00, 8'h01};
        load(c1, w);
        feed(c1, 2, -1, 0);
        drain();
        check("outs_l2", 64'(outs), 64'd32);
        check("dones_l2", 64'(dones), 64'd1);
        check("l2_ct_ready", 64'(o_ct_ready), 64'd1);
        sel = 1'b0;
        @(posedge clk);
        #1;

        // reset after 20 pixels
        outs = 0;
        dones = 0;
        load(c1, w);
        feed(c1, 0, -1, 20);
        rst_n = 1'b0;
        #1;
        check("mid_rst_pout", 64'(o_pout), 64'd0);
        check("mid_rst_valid", 64'(o_pout_valid), 64'd0);
        check("mid_rst_ct_ready", 64'(o_ct_ready), 64'd1);
        check("mid_rst_busy", 64'(o_busy), 64'd0);
        check("mid_rst_done", 64'(o_done), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drain();
        check("mid_rst_no_done", 64'(dones), 64'd0);
        outs = 0;
        load(64'hA5A5_5A5A_F00F_0FF0, w);
        feed(64'hA5A5_5A5A_F00F_0FF0, 1, -1, 0);
        drain();
        check("post_rst_outs", 64'(outs), 64'd64);
        check("post_rst_dones", 64'(dones), 64'd1);

`ifdef STEGO_BLK_CNT_EN
        rst_n = 1'b0;
        #1;
        check("cnt_rst", 64'(cnt1), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int b = 0; b < 3; b++) begin
            load(c1, w);
            feed(c1, 0, -1, 0);
        end
        drain();
        check("cnt_three", 64'(cnt1), 64'd3);
        force dut.blk_cnt = 16'hFFFE;
        #1;
        release dut.blk_cnt;
        load(c1, w);
        feed(c1, 0, -1, 0);
        drain();
        check("cnt_ffff", 64'(cnt1), 64'hFFFF);
        load(c1, w);
        feed(c1, 0, -1, 0);
        drain();
        check("cnt_wrap", 64'(cnt1), 64'd0);
`endif

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule

// File: doc/stego_lsb_embedder.md
Name: stego_lsb_embedder

Overview:
- Downstream consumer of the Triple-DES encryption stage.
- Accepts one 64-bit ciphertext block over a valid/ready handshake.
- Hides that block in the least-significant bits of a stream of cover-image pixels, then emits the modified pixels.
- Sits between the 3DES core output and the image writer in the steganography datapath.

Parameters:
- PIX_W, 8: pixel width in bits.
- BLK_W, 64: ciphertext block width in bits.
- LSB_BITS, 1: cover bits replaced per pixel. Legal values are 1, 2 and 4; BLK_W must be divisible by LSB_BITS.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ct_data  in  [1:BLK_W]  ciphertext block; bit 1 is the MSB, using DES numbering.
- ct_valid  in  1  ct_data is valid.
- ct_ready  out  1  block can be accepted.
- pix_in  in  [PIX_W-1:0]  cover pixel.
- pix_in_valid  in  1  cover pixel is valid.
- pix_in_ready  out  1  cover pixel is accepted this cycle.
- pix_out  out  [PIX_W-1:0]  stego pixel.
- pix_out_valid  out  1  stego pixel is valid.
- pix_out_ready  in  1  downstream accepts the stego pixel.
- blk_done  out  1  one-cycle pulse when the last pixel of a block is accepted.
- busy  out  1  high while state is EMBED.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - ct_ready=1, pix_in_ready=0, pix_out=0, pix_out_valid=0, blk_done=0, busy=0.
  - Internal shift register and counter cleared; state=IDLE.
- Derived constant: NPIX = BLK_W/LSB_BITS pixels per block (64 at defaults).
- FSM states:
  - IDLE: ct_ready=1, pix_in_ready=0. On ct_valid, latch ct_data into the shift register, clear the pixel counter, go to EMBED.
  - EMBED: ct_ready=0. pix_in_ready = !pix_out_valid || pix_out_ready, so there is one output register and no bubble under continuous flow. On a pixel accept:
    - pix_out <= {pix_in[PIX_W-1:LSB_BITS], sr[1:LSB_BITS]}.
    - Shift sr left by LSB_BITS.
    - Increment the counter.
    - When the counter reaches NPIX-1 on an accept: pulse blk_done and go to IDLE.
- Output register:
  - pix_out_valid sets on an accept.
  - It clears when pix_out_ready is high and there is no new accept.
  - pix_out holds stable while pix_out_valid=1 and pix_out_ready=0.
- Latency: 1 cycle from pixel accept to pix_out_valid.
- Back-to-back blocks: a ct_valid in the IDLE cycle straight after blk_done is accepted. The final pixel may still be draining from the output register; it does not block the new load.
- Bit order: ciphertext bit 1 goes into the first pixel. With LSB_BITS>1, the higher-numbered cover LSB carries the earlier ciphertext bit.
- pix_in_valid in IDLE is ignored; the pixel is not consumed.
- ct_valid in EMBED is ignored; upstream holds it.
- Reset mid-block:
  - Abandons the partial block.
  - Outputs return to reset values immediately.
  - No blk_done is generated.
- Counter width is $clog2(NPIX). Wrap-around is prevented by the NPIX-1 terminal compare.

Optional Feature:
- Macro: STEGO_BLK_CNT_EN.
- Defined:
  - Adds output blk_count [15:0], reset 0, incremented on each blk_done, wraps 16'hFFFF to 0.
  - Host uses it to know how many blocks are hidden.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package stego_pkg holds:
  - PIX_W_DEF, BLK_W_DEF and LSB_BITS_DEF constants.
  - The state typedef {IDLE, EMBED}.
  - The NPIX function.
- One natural sub-module: stego_bit_shifter. It owns the BLK_W shift register, the load, shift-by-LSB_BITS and the next-bits output. It is reused by the future extractor stage.

Test Plan:
1. Default params: ct=64'hC1F765C38141799E, 64 pixels of 8'hFF with pix_out_ready=1 -> pix_out sequence starts FF,FF,FE,FE,FE,FE,FE,FF. blk_done pulses exactly once, one cycle after the 64th accept.
2. ct=64'hFFFFFFFFFFFFFFFF, pixels 8'h00..8'h3F -> each output = input|1, i.e. 01,01,03,03,... Ends in IDLE with ct_ready=1.
3. Backpressure: hold pix_out_ready=0 for 5 cycles mid-block -> pix_out/pix_out_valid stable, pix_in_ready=0, no pixel lost or duplicated. Total outputs = 64.
4. LSB_BITS=2, ct starting 8'hC1..., pixels 8'h00 -> first four outputs 03,00,00,01. blk_done after 32 accepts.
5. Assert rst_n=0 after 20 pixels -> all outputs 0 immediately, no blk_done. A new ct_data is accepted after release.
6. With STEGO_BLK_CNT_EN: three back-to-back blocks -> blk_count=3. Preload near wrap (force) -> 16'hFFFF then 0.
